pipelined_carry_chain_adder: RTL and testbench

Parametrised successor to the team's combinational ripple-carry adder. It adds or subtracts two WIDTH-bit operands with carry/borrow-in. The carry chain is split into STAGES equal segments, with a register boundary after each segment. A valid/ready handshake with back-pressure lets it sit directly on a streaming datapath at one result per cycle. It also produces carry-out and signed overflow flags.

---
 rtl/pipelined_carry_chain_adder.sv | 114 +++++++++++
 tb/tb_pipelined_carry_chain_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_chain_adder.sv
// Pipelined add/subtract with the carry chain split into STAGES equal segments.
// Each segment adds its slice using the carry registered by the previous
// segment. Operands ride along in skew registers and finished low result bits
// ride along in de-skew registers, so one transaction's bits leave together.
// A single advance signal shifts or holds the whole pipe.
module pipelined_carry_chain_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    input  logic             Sub_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Overflow_o
);

    // Guarded so an illegal STAGES cannot cause a divide-by-zero before the check fires.
    localparam int SEG  = (STAGES >= 1) ? (WIDTH / STAGES) : 1;
    localparam int SEGW = SEG + 1;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipelined_carry_chain_adder: need WIDTH >= 2, STAGES >= 1, STAGES dividing WIDTH");
        end
    endgenerate

    // Per-stage pipeline registers; index k holds what stage k captured.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ov_q;

    // Stage inputs and next values.
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] r_in  [STAGES];
    logic [WIDTH-1:0] r_nxt [STAGES];
    logic [SEG:0]     seg_sum [STAGES];
    logic [STAGES-1:0] c_in;
    logic              msb_cin;
    logic              ov_nxt;
    logic              advance;

    assign Valid_o    = v_q[STAGES-1];
    assign Result_o   = r_q[STAGES-1];
    assign Carry_o    = c_q[STAGES-1];
    assign Overflow_o = ov_q;

    // The output register frees up whenever it is empty or being drained.
    assign advance = ~Valid_o | Ready_i;
    assign Ready_o = advance;

    // Segment adders: stage 0 takes the (possibly inverted) operands, later stages the skewed copies.
    always_comb begin
        a_in[0] = Number1_i;
        b_in[0] = Sub_i ? ~Number2_i : Number2_i;
        c_in[0] = Carry_i ^ Sub_i;
        r_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            r_in[k] = r_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                       + {1'b0, b_in[k][k*SEG +: SEG]}
                       + SEGW'(c_in[k]);
            r_nxt[k] = r_in[k];
            r_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
        // Carry into the MSB is recovered from the MSB's sum bit: s = a ^ b ^ cin.
        msb_cin = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                ^ seg_sum[STAGES-1][SEG-1];
        ov_nxt  = msb_cin ^ seg_sum[STAGES-1][SEG];
    end

    // Whole pipe shifts together on advance, including bubbles; otherwise everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (advance) begin
            v_q[0] <= Valid_i;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                r_q[k] <= r_nxt[k];
                c_q[k] <= seg_sum[k][SEG];
            end
            ov_q <= ov_nxt;
        end
    end

endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// Bench for pipelined_carry_chain_adder: three instances (32/4, 8/1, 64/8),
// an arithmetic reference model, and a queue of expected results.
module tb_pipelined_carry_chain_adder;

    logic        clk;
    logic        rst_n;
    logic [63:0] num1, num2;
    logic        carry_in, sub_in;
    logic [2:0]  valid_in, ready_in;
    logic [2:0]  ready_o, vo, co, ovo;
    logic [31:0] res0;
    logic [7:0]  res1;
    logic [63:0] res2;

    int checks = 0;
    int errors = 0;
    logic [65:0] sb_q [$];

    pipelined_carry_chain_adder #(.WIDTH(32), .STAGES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .Valid_i(valid_in[0]), .Ready_o(ready_o[0]),
        .Number1_i(num1[31:0]), .Number2_i(num2[31:0]), .Carry_i(carry_in), .Sub_i(sub_in),
        .Valid_o(vo[0]), .Ready_i(ready_in[0]), .Result_o(res0), .Carry_o(co[0]), .Overflow_o(ovo[0]));

    pipelined_carry_chain_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Valid_i(valid_in[1]), .Ready_o(ready_o[1]),
        .Number1_i(num1[7:0]), .Number2_i(num2[7:0]), .Carry_i(carry_in), .Sub_i(sub_in),
        .Valid_o(vo[1]), .Ready_i(ready_in[1]), .Result_o(res1), .Carry_o(co[1]), .Overflow_o(ovo[1]));

    pipelined_carry_chain_adder #(.WIDTH(64), .STAGES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .Valid_i(valid_in[2]), .Ready_o(ready_o[2]),
        .Number1_i(num1), .Number2_i(num2), .Carry_i(carry_in), .Sub_i(sub_in),
        .Valid_o(vo[2]), .Ready_i(ready_in[2]), .Result_o(res2), .Carry_o(co[2]), .Overflow_o(ovo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dut_width(input int sel);
        return (sel == 0) ? 32 : (sel == 1) ? 8 : 64;
    endfunction

    function automatic int dut_stages(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
    endfunction

    function automatic logic [63:0] dut_res(input int sel);
        if (sel == 0) return {32'b0, res0};
        if (sel == 1) return {56'b0, res1};
        return res2;
    endfunction

    // Reference: {overflow, carry, result}, computed from plain integer arithmetic and operand signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [127:0] mask, aa, bb, t;
        logic [63:0]  r;
        logic         c, ov, sa, sb, sr;
        mask = (128'd1 << w) - 128'd1;
        aa = {64'b0, a} & mask;
        bb = {64'b0, b} & mask;
        if (!sub) begin
            t = aa + bb + {127'b0, cin};
            c = t[w];
        end else begin
            t = aa - bb - {127'b0, cin};
            c = (aa >= bb + {127'b0, cin});
        end
        r  = t[63:0] & mask[63:0];
        sa = aa[w-1];
        sb = bb[w-1];
        sr = r[w-1];
        ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {ov, c, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        valid_in = '0; ready_in = '1;
        num1 = '0; num2 = '0; carry_in = 1'b0; sub_in = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (vo !== 3'b000 || ready_o !== 3'b111)
            begin errors++; $display("FAIL reset_handshake: valid=%b ready=%b, need 000/111", vo, ready_o); end
        checks++;
        if (res0 !== 32'd0 || res1 !== 8'd0 || res2 !== 64'd0 || co !== 3'b000 || ovo !== 3'b000)
            begin errors++; $display("FAIL reset_outputs: res0=%h res1=%h res2=%h c=%b ov=%b, need zeros", res0, res1, res2, co, ovo); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (vo !== 3'b000 || ready_o !== 3'b111)
            begin errors++; $display("FAIL post_reset: valid=%b ready=%b, need 000/111", vo, ready_o); end
    endtask

    // One isolated transaction: checks acceptance, latency, the result, and single delivery.
    task automatic do_single(input int sel, input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic sub);
        logic [65:0] exp;
        int lat;
        sb_q.push_back(model(dut_width(sel), a, b, cin, sub));
        @(negedge clk);
        num1 = a; num2 = b; carry_in = cin; sub_in = sub;
        valid_in[sel] = 1'b1; ready_in[sel] = 1'b1;
        #1;
        checks++;
        if (ready_o[sel] !== 1'b1)
            begin errors++; $display("FAIL single_accept dut%0d: ready=%b, need 1", sel, ready_o[sel]); end
        @(posedge clk); #1;
        valid_in[sel] = 1'b0;
        lat = 1;
        while (vo[sel] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != dut_stages(sel))
            begin errors++; $display("FAIL latency dut%0d: got %0d cycles, need %0d", sel, lat, dut_stages(sel)); end
        exp = sb_q.pop_front();
        checks++;
        if (dut_res(sel) !== exp[63:0] || co[sel] !== exp[64] || ovo[sel] !== exp[65])
            begin errors++; $display("FAIL arith dut%0d a=%h b=%h cin=%b sub=%b: got r=%h c=%b ov=%b, need r=%h c=%b ov=%b",
                                     sel, a, b, cin, sub, dut_res(sel), co[sel], ovo[sel], exp[63:0], exp[64], exp[65]); end
        @(posedge clk); #1;
        checks++;
        if (vo[sel] !== 1'b0)
            begin errors++; $display("FAIL single_once dut%0d: valid=%b after accept, need 0", sel, vo[sel]); end
    endtask

    task automatic test_arith(input int sel);
        int w;
        logic [63:0] m, msb;
        w   = dut_width(sel);
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        msb = 64'd1 << (w - 1);
        do_single(sel, m, 64'd1, 1'b0, 1'b0);
        do_single(sel, m, 64'd1, 1'b1, 1'b0);
        do_single(sel, m >> 1, 64'd1, 1'b0, 1'b0);
        do_single(sel, 64'd5, 64'd7, 1'b0, 1'b1);
        do_single(sel, msb, 64'd1, 1'b0, 1'b1);
        do_single(sel, 64'd10, 64'd3, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0;
        logic [31:0] held;
        logic [65:0] exp;
        sb_q.delete();
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            ready_in[0] = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                valid_in[0] = 1'b1; num1 = 64'(sent); num2 = 64'(sent);
                carry_in = 1'b0; sub_in = 1'b0;
            end else begin
                valid_in[0] = 1'b0;
            end
            #1;
            if (cyc == 6) held = res0;
            if (cyc >= 6 && cyc <= 8) begin
                checks++;
                if (ready_o[0] !== 1'b0 || vo[0] !== 1'b1 || res0 !== held)
                    begin errors++; $display("FAIL stall cyc%0d: ready=%b valid=%b r=%h, need 0/1/%h", cyc, ready_o[0], vo[0], res0, held); end
            end
            if (vo[0] && ready_in[0]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: output r=%h with nothing outstanding", res0);
                end else begin
                    exp = sb_q.pop_front();
                    if (res0 !== exp[31:0] || res0 !== 32'(2 * got) || co[0] !== exp[64] || ovo[0] !== exp[65])
                        begin errors++; $display("FAIL b2b_result #%0d: got r=%h c=%b ov=%b, need r=%h c=%b ov=%b",
                                                 got, res0, co[0], ovo[0], exp[31:0], exp[64], exp[65]); end
                end
                got++;
            end
            if (valid_in[0] && ready_o[0]) begin
                sb_q.push_back(model(32, num1, num2, carry_in, sub_in));
                sent++;
            end
            cyc++;
            @(posedge clk);
        end
        valid_in[0] = 1'b0; ready_in[0] = 1'b1;
        checks++;
        if (got != 8 || sent != 8 || sb_q.size() != 0)
            begin errors++; $display("FAIL b2b_count: got %0d sent %0d pending %0d, need 8/8/0", got, sent, sb_q.size()); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (vo[0] !== 1'b0)
            begin errors++; $display("FAIL b2b_drain: valid=%b after drain, need 0", vo[0]); end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, cyc = 0, bad = 0;
        logic [65:0] exp;
        sb_q.delete();
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk);
            ready_in[0] = ($urandom_range(3) != 0);
            valid_in[0] = (sent < 10000) && ($urandom_range(4) != 0);
            num1 = {32'b0, $urandom()};
            num2 = {32'b0, $urandom()};
            carry_in = $urandom_range(1) == 1;
            sub_in   = $urandom_range(1) == 1;
            #1;
            if (vo[0] && ready_in[0]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_extra: output r=%h with nothing outstanding", res0);
                end else begin
                    exp = sb_q.pop_front();
                    if (res0 !== exp[31:0] || co[0] !== exp[64] || ovo[0] !== exp[65]) begin
                        errors++; bad++;
                        if (bad < 10) $display("FAIL rand_result #%0d: got r=%h c=%b ov=%b, need r=%h c=%b ov=%b",
                                               got, res0, co[0], ovo[0], exp[31:0], exp[64], exp[65]);
                    end
                end
                got++;
            end
            if (valid_in[0] && ready_o[0]) begin
                sb_q.push_back(model(32, num1, num2, carry_in, sub_in));
                sent++;
            end
            cyc++;
            @(posedge clk);
        end
        valid_in[0] = 1'b0; ready_in[0] = 1'b1;
        checks++;
        if (got != 10000 || sb_q.size() != 0)
            begin errors++; $display("FAIL rand_count: got %0d pending %0d, need 10000/0", got, sb_q.size()); end
    endtask

    task automatic test_reset_midflight();
        int n;
        @(negedge clk);
        ready_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in[0] = 1'b1; num1 = 64'(100 + i); num2 = 64'(7 * i + 1);
            carry_in = 1'b0; sub_in = 1'b0;
            @(negedge clk);
        end
        valid_in[0] = 1'b0;
        n = 0;
        while (vo[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (vo[0] !== 1'b1 || res0 === 32'd0)
            begin errors++; $display("FAIL midflight_fill: valid=%b r=%h, need 1 and nonzero", vo[0], res0); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vo[0] !== 1'b0 || res0 !== 32'd0 || co[0] !== 1'b0 || ovo[0] !== 1'b0 || ready_o[0] !== 1'b1)
            begin errors++; $display("FAIL midflight_clear: valid=%b r=%h c=%b ov=%b ready=%b, need 0/0/0/0/1",
                                     vo[0], res0, co[0], ovo[0], ready_o[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        ready_in[0] = 1'b1;
        sb_q.delete();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vo[0] !== 1'b0) n++;
        end
        checks++;
        if (n != 0)
            begin errors++; $display("FAIL midflight_stale: valid seen on %0d cycles after reset, need 0", n); end
        do_single(0, 64'h0012_3456, 64'h0065_4321, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arith(0);
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_arith(1);
        test_arith(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
